// File: rtl/cam_pixel_fifo_sync_if.sv
// Pixel bus between the camera remapper (writer), the pixel FIFO and the
// DMA/frame-buffer writer (reader). The FIFO is the slave side.
interface cam_pixel_fifo_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  prog_full_o;
  logic                  empty_o;
  logic                  almost_empty_o;
  logic                  prog_empty_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic                  wr_ack_o;
  logic [ADDR_WIDTH:0]   datacount_o;

  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  rdata_o, rd_valid_o, full_o, almost_full_o, prog_full_o,
           empty_o, almost_empty_o, prog_empty_o, overflow_o, underflow_o,
           wr_ack_o, datacount_o
  );

  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output rdata_o, rd_valid_o, full_o, almost_full_o, prog_full_o,
           empty_o, almost_empty_o, prog_empty_o, overflow_o, underflow_o,
           wr_ack_o, datacount_o
  );
endinterface

// File: rtl/cam_pixel_fifo_sync.sv
// Single-clock pixel FIFO with STANDARD (registered read) or FWFT output,
// registered full/empty/threshold flags with hysteresis and an occupancy count.
// In FWFT mode the count includes the word sitting in the output register.
module cam_pixel_fifo_sync #(
  parameter int    DATA_WIDTH        = 32,
  parameter int    ADDR_WIDTH        = 9,
  parameter string MODE              = "STANDARD",
  parameter int    PROG_FULL_ASSERT  = (1 << ADDR_WIDTH) - 4,
  parameter int    PROG_FULL_NEGATE  = (1 << ADDR_WIDTH) - 8,
  parameter int    PROG_EMPTY_ASSERT = 4,
  parameter int    PROG_EMPTY_NEGATE = 8
) (
  input logic                  clk_i,
  input logic                  a_rstn_i,
  cam_pixel_fifo_sync_if.slave bus
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam bit IS_FWFT = (MODE == "FWFT");

  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL = CNT_FULL - CNT_ONE;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   PF_SET    = PROG_FULL_ASSERT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   PF_CLR    = PROG_FULL_NEGATE[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   PE_SET    = PROG_EMPTY_ASSERT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   PE_CLR    = PROG_EMPTY_NEGATE[ADDR_WIDTH:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  state_t                state;

  logic wr_accept;
  logic rd_accept;
  logic hold_refill;
  logic ram_rd_en;

  // empty_o is !HOLD in FWFT and count==0 in STANDARD, so one rule covers both
  assign wr_accept   = bus.wr_en_i && !bus.full_o;
  assign rd_accept   = bus.rd_en_i && !bus.empty_o;
  // in HOLD, a stored word beyond the output register lets a pop reload without a bubble
  assign hold_refill = (state == S_HOLD) && (count > CNT_ONE);
  assign ram_rd_en   = IS_FWFT ? ((state == S_FETCH) || (rd_accept && hold_refill))
                               : rd_accept;

  // Occupancy after this edge; flags are computed from it so they track the new count
  always_comb begin
    count_next = count;
    if (wr_accept && !rd_accept) begin
      count_next = count + CNT_ONE;
    end else if (!wr_accept && rd_accept) begin
      count_next = count - CNT_ONE;
    end
  end

  // Storage array write port, no reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wdata_i;
    end
  end

  // Pointers, count, read register, prefetch FSM and all registered flags
  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      state              <= S_IDLE;
      bus.rdata_o        <= '0;
      bus.rd_valid_o     <= 1'b0;
      bus.full_o         <= 1'b0;
      bus.almost_full_o  <= 1'b0;
      bus.prog_full_o    <= 1'b0;
      bus.empty_o        <= 1'b1;
      bus.almost_empty_o <= 1'b1;
      bus.prog_empty_o   <= 1'b1;
      bus.overflow_o     <= 1'b0;
      bus.underflow_o    <= 1'b0;
      bus.wr_ack_o       <= 1'b0;
      bus.datacount_o    <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_rd_en) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        bus.rdata_o <= mem[rd_ptr];
      end

      count              <= count_next;
      bus.datacount_o    <= count_next;
      bus.wr_ack_o       <= wr_accept;
      bus.overflow_o     <= bus.wr_en_i && bus.full_o;
      bus.underflow_o    <= bus.rd_en_i && bus.empty_o;
      bus.full_o         <= (count_next == CNT_FULL);
      bus.almost_full_o  <= (count_next >= CNT_AFULL);
      bus.almost_empty_o <= (count_next <= CNT_ONE);

      if (count_next >= PF_SET) begin
        bus.prog_full_o <= 1'b1;
      end else if (count_next < PF_CLR) begin
        bus.prog_full_o <= 1'b0;
      end

      if (count_next <= PE_SET) begin
        bus.prog_empty_o <= 1'b1;
      end else if (count_next > PE_CLR) begin
        bus.prog_empty_o <= 1'b0;
      end

      if (IS_FWFT) begin
        case (state)
          S_IDLE: begin
            if ((count != '0) || wr_accept) begin
              state <= S_FETCH;
            end
          end
          S_FETCH: begin
            state          <= S_HOLD;
            bus.empty_o    <= 1'b0;
            bus.rd_valid_o <= 1'b1;
          end
          S_HOLD: begin
            if (rd_accept && !hold_refill) begin
              state          <= wr_accept ? S_FETCH : S_IDLE;
              bus.empty_o    <= 1'b1;
              bus.rd_valid_o <= 1'b0;
            end
          end
          default: begin
            state          <= S_IDLE;
            bus.empty_o    <= 1'b1;
            bus.rd_valid_o <= 1'b0;
          end
        endcase
      end else begin
        state          <= S_IDLE;
        bus.empty_o    <= (count_next == '0);
        bus.rd_valid_o <= rd_accept;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_fifo_sync.sv
// Directed bench for cam_pixel_fifo_sync: one STANDARD and one FWFT instance,
// a short vector table plus hand-written fill/drain/stream/reset sequences.
module tb_cam_pixel_fifo_sync;

  localparam int DW = 32;
  localparam int AW = 9;

  typedef struct {
    logic          wr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic [AW:0]   count;
    logic          empty;
    logic          aempty;
    logic          valid;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [9];

  // Free-running clock, period 10
  always #5 clk = ~clk;

  cam_pixel_fifo_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_s ();
  cam_pixel_fifo_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_f ();

  cam_pixel_fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE("STANDARD")) dut_std (
    .clk_i    (clk),
    .a_rstn_i (rst_n),
    .bus      (if_s)
  );

  cam_pixel_fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE("FWFT")) dut_fwft (
    .clk_i    (clk),
    .a_rstn_i (rst_n),
    .bus      (if_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s_wr, input logic s_rd, input logic f_wr,
                               input logic f_rd, input logic [DW-1:0] wdata);
    if_s.wr_en_i = s_wr;
    if_s.rd_en_i = s_rd;
    if_s.wdata_i = wdata;
    if_f.wr_en_i = f_wr;
    if_f.rd_en_i = f_rd;
    if_f.wdata_i = wdata;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag, input logic [DW-1:0] rdata,
                                  input logic valid, input logic full, input logic afull,
                                  input logic pfull, input logic empty, input logic aempty,
                                  input logic pempty, input logic ovf, input logic unf,
                                  input logic ack, input logic [AW:0] cnt);
    checkOutput({tag, "_rdata"},  64'(rdata),  64'(0));
    checkOutput({tag, "_valid"},  64'(valid),  64'(0));
    checkOutput({tag, "_full"},   64'(full),   64'(0));
    checkOutput({tag, "_afull"},  64'(afull),  64'(0));
    checkOutput({tag, "_pfull"},  64'(pfull),  64'(0));
    checkOutput({tag, "_empty"},  64'(empty),  64'(1));
    checkOutput({tag, "_aempty"}, 64'(aempty), 64'(1));
    checkOutput({tag, "_pempty"}, 64'(pempty), 64'(1));
    checkOutput({tag, "_ovf"},    64'(ovf),    64'(0));
    checkOutput({tag, "_unf"},    64'(unf),    64'(0));
    checkOutput({tag, "_ack"},    64'(ack),    64'(0));
    checkOutput({tag, "_count"},  64'(cnt),    64'(0));
  endtask

  task automatic checkBothReset(input string tag);
    checkResetValues({tag, "_std"}, if_s.rdata_o, if_s.rd_valid_o, if_s.full_o,
                     if_s.almost_full_o, if_s.prog_full_o, if_s.empty_o, if_s.almost_empty_o,
                     if_s.prog_empty_o, if_s.overflow_o, if_s.underflow_o, if_s.wr_ack_o,
                     if_s.datacount_o);
    checkResetValues({tag, "_fwft"}, if_f.rdata_o, if_f.rd_valid_o, if_f.full_o,
                     if_f.almost_full_o, if_f.prog_full_o, if_f.empty_o, if_f.almost_empty_o,
                     if_f.prog_empty_o, if_f.overflow_o, if_f.underflow_o, if_f.wr_ack_o,
                     if_f.datacount_o);
  endtask

  // Safety net so the run always ends even if the sequence stalls
  initial begin
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    int ack_s;
    int ack_f;
    int cnt;
    logic [DW-1:0] base;

    // wr, wdata, rd | count, empty, aempty, valid, rdata, ack, unf  (STANDARD instance)
    vecs[0] = '{1'b1, 32'h11, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h22, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h00, 1'b1, 10'd1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h33, 1'b1, 10'd1, 1'b0, 1'b1, 1'b1, 32'h22, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 10'd0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 32'h33, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h44, 1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'h00, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h00, 1'b1, 10'd0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0};

    if_s.wr_en_i = 1'b0; if_s.rd_en_i = 1'b0; if_s.wdata_i = '0;
    if_f.wr_en_i = 1'b0; if_f.rd_en_i = 1'b0; if_f.wdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkBothReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, 1'b0, 1'b0, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_count", i),  64'(if_s.datacount_o),    64'(vecs[i].count));
      checkOutput($sformatf("vec%0d_empty", i),  64'(if_s.empty_o),        64'(vecs[i].empty));
      checkOutput($sformatf("vec%0d_aempty", i), 64'(if_s.almost_empty_o), 64'(vecs[i].aempty));
      checkOutput($sformatf("vec%0d_valid", i),  64'(if_s.rd_valid_o),     64'(vecs[i].valid));
      checkOutput($sformatf("vec%0d_rdata", i),  64'(if_s.rdata_o),        64'(vecs[i].rdata));
      checkOutput($sformatf("vec%0d_ack", i),    64'(if_s.wr_ack_o),       64'(vecs[i].ack));
      checkOutput($sformatf("vec%0d_unf", i),    64'(if_s.underflow_o),    64'(vecs[i].unf));
    end

    $display("[TB] FWFT single word into empty FIFO");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
    checkOutput("fwft_w1_count", 64'(if_f.datacount_o), 64'(1));
    checkOutput("fwft_w1_empty", 64'(if_f.empty_o),     64'(1));
    checkOutput("fwft_w1_valid", 64'(if_f.rd_valid_o),  64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fwft_w2_empty", 64'(if_f.empty_o),     64'(0));
    checkOutput("fwft_w2_valid", 64'(if_f.rd_valid_o),  64'(1));
    checkOutput("fwft_w2_rdata", 64'(if_f.rdata_o),     64'(32'hA5A5_0001));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("fwft_pop_empty", 64'(if_f.empty_o),        64'(1));
    checkOutput("fwft_pop_count", 64'(if_f.datacount_o),    64'(0));
    checkOutput("fwft_pop_valid", 64'(if_f.rd_valid_o),     64'(0));
    checkOutput("fwft_pop_ae",    64'(if_f.almost_empty_o), 64'(1));

    $display("[TB] fill both instances with 0..511");
    ack_s = 0;
    ack_f = 0;
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'(i));
      cnt = i + 1;
      if (if_s.wr_ack_o) ack_s++;
      if (if_f.wr_ack_o) ack_f++;
      checkOutput("fill_count_std",  64'(if_s.datacount_o),  64'(cnt));
      checkOutput("fill_count_fwft", 64'(if_f.datacount_o),  64'(cnt));
      checkOutput("fill_full_std",   64'(if_s.full_o),        64'(cnt == 512));
      checkOutput("fill_full_fwft",  64'(if_f.full_o),        64'(cnt == 512));
      checkOutput("fill_afull_std",  64'(if_s.almost_full_o), 64'(cnt >= 511));
      checkOutput("fill_pfull_std",  64'(if_s.prog_full_o),   64'(cnt >= 508));
      checkOutput("fill_pempty_std", 64'(if_s.prog_empty_o),  64'(cnt <= 8));
    end
    checkOutput("fill_acks_std",   64'(ack_s),           64'(512));
    checkOutput("fill_acks_fwft",  64'(ack_f),           64'(512));
    checkOutput("fill_head_fwft",  64'(if_f.rdata_o),    64'(0));
    checkOutput("fill_empty_fwft", 64'(if_f.empty_o),    64'(0));

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    checkOutput("ovf_std",        64'(if_s.overflow_o),  64'(1));
    checkOutput("ovf_fwft",       64'(if_f.overflow_o),  64'(1));
    checkOutput("ovf_ack_std",    64'(if_s.wr_ack_o),    64'(0));
    checkOutput("ovf_count_std",  64'(if_s.datacount_o), 64'(512));
    checkOutput("ovf_count_fwft", 64'(if_f.datacount_o), 64'(512));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ovf_pulse_end",  64'(if_s.overflow_o),  64'(0));

    $display("[TB] drain both instances");
    for (int i = 0; i < 512; i++) begin
      checkOutput("drain_head_fwft",  64'(if_f.rdata_o), 64'(i));
      checkOutput("drain_empty_fwft", 64'(if_f.empty_o), 64'(0));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      cnt = 511 - i;
      checkOutput("drain_rdata_std",  64'(if_s.rdata_o),        64'(i));
      checkOutput("drain_valid_std",  64'(if_s.rd_valid_o),     64'(1));
      checkOutput("drain_count_std",  64'(if_s.datacount_o),    64'(cnt));
      checkOutput("drain_count_fwft", 64'(if_f.datacount_o),    64'(cnt));
      checkOutput("drain_pfull_std",  64'(if_s.prog_full_o),    64'(cnt >= 504));
      checkOutput("drain_pempty_std", 64'(if_s.prog_empty_o),   64'(cnt <= 4));
      checkOutput("drain_aempty_std", 64'(if_s.almost_empty_o), 64'(cnt <= 1));
      checkOutput("drain_empty_std",  64'(if_s.empty_o),        64'(cnt == 0));
    end
    checkOutput("drain_end_fwft_empty", 64'(if_f.empty_o), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    checkOutput("unf_std",        64'(if_s.underflow_o), 64'(1));
    checkOutput("unf_fwft",       64'(if_f.underflow_o), 64'(1));
    checkOutput("unf_hold_rdata", 64'(if_s.rdata_o),     64'(511));
    checkOutput("unf_valid_std",  64'(if_s.rd_valid_o),  64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("unf_pulse_end",  64'(if_s.underflow_o), 64'(0));

    $display("[TB] streaming at count 256 for 2000 cycles");
    base = 32'h1000_0000;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, base + 32'(i));
    end
    for (int c = 0; c < 2000; c++) begin
      checkOutput("stream_head_fwft",  64'(if_f.rdata_o), 64'(base + 32'(c)));
      checkOutput("stream_empty_fwft", 64'(if_f.empty_o), 64'(0));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, base + 32'(256 + c));
      checkOutput("stream_rdata_std",  64'(if_s.rdata_o),     64'(base + 32'(c)));
      checkOutput("stream_valid_std",  64'(if_s.rd_valid_o),  64'(1));
      checkOutput("stream_count_std",  64'(if_s.datacount_o), 64'(256));
      checkOutput("stream_count_fwft", 64'(if_f.datacount_o), 64'(256));
    end

    $display("[TB] asynchronous reset at count 100");
    for (int k = 0; k < 156; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    end
    checkOutput("prereset_count_std",  64'(if_s.datacount_o), 64'(100));
    checkOutput("prereset_count_fwft", 64'(if_f.datacount_o), 64'(100));
    if_s.wr_en_i = 1'b1; if_s.rd_en_i = 1'b0; if_s.wdata_i = 32'h5555_0000;
    if_f.wr_en_i = 1'b1; if_f.rd_en_i = 1'b0; if_f.wdata_i = 32'h5555_0000;
    #3;
    rst_n = 1'b0;
    #1;
    checkBothReset("midreset");
    tick();
    checkOutput("inreset_count_std",  64'(if_s.datacount_o), 64'(0));
    checkOutput("inreset_count_fwft", 64'(if_f.datacount_o), 64'(0));
    if_s.wr_en_i = 1'b0;
    if_f.wr_en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'hBEEF_0001);
    checkOutput("post_count_std",  64'(if_s.datacount_o), 64'(1));
    checkOutput("post_count_fwft", 64'(if_f.datacount_o), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("post_rdata_std",  64'(if_s.rdata_o),    64'(32'hBEEF_0001));
    checkOutput("post_valid_std",  64'(if_s.rd_valid_o), 64'(1));
    checkOutput("post_empty_fwft", 64'(if_f.empty_o),    64'(0));
    checkOutput("post_rdata_fwft", 64'(if_f.rdata_o),    64'(32'hBEEF_0001));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("post_pop_count_fwft", 64'(if_f.datacount_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
